// File: rtl/fpu_fadd_iter_pkg.sv
// Shared definitions for the iterative floating-point adder.
// Holds FSM states, flag indices, rounding modes and the qNaN builder.
package fpu_fadd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLASS,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_e;

   localparam int FLAG_NV = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic RM_RNE = 1'b0;
   localparam logic RM_RTZ = 1'b1;

   // Sign 0, exponent all ones, fraction MSB set; callers truncate to W.
   function automatic logic [255:0] canon_qnan(
      input int exp_w,
      input int man_w
   );
      logic [255:0] q;
      q = ((256'(1) << exp_w) - 256'(1)) << man_w;
      q = q | (256'(1) << (man_w - 1));
      return q;
   endfunction

endpackage

// File: rtl/fpu_fadd_iter_lzc.sv
// Combinational leading-zero counter used by the adder's normaliser.
// Ports: in_i (N bits), cnt_o (leading zeros, N when empty), zero_o.
module fpu_lzc #(
   parameter int N = 25
) (
   input  logic [N-1:0]           in_i,
   output logic [$clog2(N+1)-1:0] cnt_o,
   output logic                   zero_o
);
   localparam int CW = $clog2(N + 1);

   // Scan upward so the highest set bit wins.
   always_comb begin
      cnt_o = CW'(N);
      for (int i = 0; i < N; i++) begin
         if (in_i[i]) cnt_o = CW'(N - 1 - i);
      end
   end

   assign zero_o = ~|in_i;

endmodule

// File: rtl/fpu_fadd_iter.sv
// Multi-cycle IEEE-754 add/subtract with RNE/RTZ, DAZ/FTZ, flags.
// Ports: clk, rst, issue i_valid/i_ready/i_op/i_rm/i_a/i_b,
// result o_valid/o_ready/o_result/o_flags {NV,OF,UF,NX}.
module fpu_fadd_iter
   import fpu_fadd_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic         i_op,
   input  logic         i_rm,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [W-1:0] o_result,
   output logic [3:0]   o_flags
);
   localparam int XW   = MAN_W + 4;
   localparam int EW   = EXP_W + 2;
   localparam int LW   = MAN_W + 2;
   localparam int CW   = $clog2(LW + 1);
   localparam int EMAX = (1 << EXP_W) - 1;
   localparam logic [W-1:0] QNAN =
      W'(canon_qnan(EXP_W, MAN_W));

   state_e               state_q, state_d;
   logic [W-1:0]         a_q, a_d;
   logic [W-1:0]         b_q, b_d;
   logic [W-1:0]         res_q, res_d;
   logic [3:0]           flg_q, flg_d;
   logic                 rm_q, rm_d;
   logic                 sgn_q, sgn_d;
   logic                 sub_q, sub_d;
   logic signed [EW-1:0] exp_q, exp_d;
   logic [XW-1:0]        lm_q, lm_d;
   logic [XW-1:0]        sm_q, sm_d;
   logic [XW:0]          man_q, man_d;

   // Operand decode
   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_nan, b_nan, a_snan, b_snan;
   logic             a_inf, b_inf, a_zero, b_zero;

   assign {sa, ea, fa} = a_q;
   assign {sb, eb, fb} = b_q;

   assign a_nan  = (&ea) & (|fa);
   assign b_nan  = (&eb) & (|fb);
   assign a_snan = a_nan & ~fa[MAN_W-1];
   assign b_snan = b_nan & ~fb[MAN_W-1];
   assign a_inf  = (&ea) & ~(|fa);
   assign b_inf  = (&eb) & ~(|fb);
   // Subnormals count as zero.
   assign a_zero = ~(|ea);
   assign b_zero = ~(|eb);

   logic         spec;
   logic [W-1:0] spec_res;
   logic [3:0]   spec_flg;

   always_comb begin
      spec     = 1'b1;
      spec_res = '0;
      spec_flg = '0;
      if (a_nan | b_nan) begin
         spec_res          = QNAN;
         spec_flg[FLAG_NV] = a_snan | b_snan;
      end else if (a_inf & b_inf & (sa ^ sb)) begin
         spec_res          = QNAN;
         spec_flg[FLAG_NV] = 1'b1;
      end else if (a_inf) begin
         spec_res = a_q;
      end else if (b_inf) begin
         spec_res = b_q;
      end else if (a_zero & b_zero) begin
         spec_res = {sa & sb, {(W-1){1'b0}}};
      end else if (a_zero) begin
         spec_res = b_q;
      end else if (b_zero) begin
         spec_res = a_q;
      end else begin
         spec = 1'b0;
      end
   end

   // Alignment: both operands are normal here, so the
   // magnitude compare is a plain unsigned compare.
   logic             a_big, ls, ss;
   logic [EXP_W-1:0] le, se, dexp;
   logic [MAN_W-1:0] lf, sf;
   logic [XW-1:0]    sext, sshf;

   assign a_big = a_q[W-2:0] >= b_q[W-2:0];
   assign ls    = a_big ? sa : sb;
   assign ss    = a_big ? sb : sa;
   assign le    = a_big ? ea : eb;
   assign se    = a_big ? eb : ea;
   assign lf    = a_big ? fa : fb;
   assign sf    = a_big ? fb : fa;
   assign dexp  = le - se;
   assign sext  = {1'b1, sf, 3'b000};

   always_comb begin
      sshf = '0;
      if (32'(dexp) > 32'(XW - 1)) begin
         sshf = XW'(1);
      end else begin
         sshf    = sext >> dexp;
         sshf[0] = sshf[0] |
            (|(sext & ~({XW{1'b1}} << dexp)));
      end
   end

   // Large operand always wins, so subtraction never borrows out.
   logic [XW:0] sum;

   assign sum = sub_q ?
      ({1'b0, lm_q} - {1'b0, sm_q}) :
      ({1'b0, lm_q} + {1'b0, sm_q});

   // Cancellation only leaves a leading one at or above guard,
   // so the counter covers hidden, fraction and guard.
   logic [CW-1:0] lz;
   logic          lz_zero;

   fpu_lzc #(
      .N (LW)
   ) u_lzc (
      .in_i   (man_q[XW-1:2]),
      .cnt_o  (lz),
      .zero_o (lz_zero)
   );

   // Rounding
   logic                 g, r, s, lsb, inc;
   logic [MAN_W+1:0]     rnd;
   logic signed [EW-1:0] rexp;
   logic [MAN_W-1:0]     rfrac;
   logic [W-1:0]         rres;
   logic [3:0]           rflg;

   assign lsb  = man_q[3];
   assign g    = man_q[2];
   assign r    = man_q[1];
   assign s    = man_q[0];
   assign inc  = (rm_q == RM_RNE) & g & (r | s | lsb);
   assign rnd  = {1'b0, man_q[XW-1:3]} +
                 {{(MAN_W+1){1'b0}}, inc};
   assign rexp = rnd[MAN_W+1] ? exp_q + EW'(1) : exp_q;
   assign rfrac = rnd[MAN_W+1] ? '0 : rnd[MAN_W-1:0];

   always_comb begin
      rres          = {sgn_q, rexp[EXP_W-1:0], rfrac};
      rflg          = '0;
      rflg[FLAG_NX] = g | r | s;
      if (rexp >= EW'(EMAX)) begin
         rflg[FLAG_OF] = 1'b1;
         rflg[FLAG_NX] = 1'b1;
         if (rm_q == RM_RTZ)
            rres = {sgn_q, {(EXP_W-1){1'b1}}, 1'b0,
                    {MAN_W{1'b1}}};
         else
            rres = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (rexp < EW'(1)) begin
         rflg[FLAG_UF] = 1'b1;
         rflg[FLAG_NX] = 1'b1;
         rres          = {sgn_q, {(W-1){1'b0}}};
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      rm_d    = rm_q;
      res_d   = res_q;
      flg_d   = flg_q;
      sgn_d   = sgn_q;
      sub_d   = sub_q;
      exp_d   = exp_q;
      lm_d    = lm_q;
      sm_d    = sm_q;
      man_d   = man_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               a_d     = i_a;
               b_d     = {i_b[W-1] ^ i_op, i_b[W-2:0]};
               rm_d    = i_rm;
               state_d = S_CLASS;
            end
         end
         S_CLASS: begin
            if (spec) begin
               res_d   = spec_res;
               flg_d   = spec_flg;
               state_d = S_DONE;
            end else begin
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            lm_d    = {1'b1, lf, 3'b000};
            sm_d    = sshf;
            exp_d   = $signed(EW'(le));
            sgn_d   = ls;
            sub_d   = ls ^ ss;
            state_d = S_ADD;
         end
         S_ADD: begin
            if (sum == '0) begin
               res_d   = '0;
               flg_d   = '0;
               state_d = S_DONE;
            end else begin
               man_d   = sum;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            state_d = S_ROUND;
            if (man_q[XW]) begin
               man_d = {1'b0, man_q[XW:2],
                        man_q[1] | man_q[0]};
               exp_d = exp_q + EW'(1);
            end else if (lz_zero) begin
               res_d   = '0;
               flg_d   = '0;
               state_d = S_DONE;
            end else begin
               man_d = man_q << lz;
               exp_d = exp_q - $signed(EW'(lz));
            end
         end
         S_ROUND: begin
            res_d   = rres;
            flg_d   = rflg;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (o_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      rm_q  <= rm_d;
      sgn_q <= sgn_d;
      sub_q <= sub_d;
      exp_q <= exp_d;
      lm_q  <= lm_d;
      sm_q  <= sm_d;
      man_q <= man_d;
   end

   assign i_ready  = (state_q == S_IDLE);
   assign o_valid  = (state_q == S_DONE);
   assign o_result = res_q;
   assign o_flags  = flg_q;

endmodule

// File: tb/tb_fpu_fadd_iter.sv
// Randomised and directed bench for fpu_fadd_iter (binary32).
// Reference is exact integer arithmetic rounded per IEEE rules.
module tb_fpu_fadd_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        i_ready;
   logic        i_op;
   logic        i_rm;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_result;
   logic [3:0]  o_flags;

   int total = 0;
   int bad   = 0;

   fpu_fadd_iter dut (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .i_op     (i_op),
      .i_rm     (i_rm),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o_result (o_result),
      .o_flags  (o_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Result, flags {NV,OF,UF,NX} and latency from IEEE rules.
   function automatic void model(
      input  logic [31:0] a,
      input  logic [31:0] b,
      input  bit          op,
      input  bit          rm,
      output logic [31:0] r,
      output logic [3:0]  f,
      output int          lat
   );
      logic [31:0]  be;
      bit           sa, sb, an, bn, asn, bsn;
      bit           ai, bi, az, bz, s, nx;
      int           ea, eb, base, p, sh, e;
      logic [127:0] A, B, M, q, rem, half;
      be  = {b[31] ^ op, b[30:0]};
      sa  = a[31];
      sb  = be[31];
      ea  = int'(a[30:23]);
      eb  = int'(be[30:23]);
      an  = (ea == 255) && (a[22:0] != 0);
      bn  = (eb == 255) && (be[22:0] != 0);
      asn = an && !a[22];
      bsn = bn && !be[22];
      ai  = (ea == 255) && (a[22:0] == 0);
      bi  = (eb == 255) && (be[22:0] == 0);
      az  = (ea == 0);
      bz  = (eb == 0);
      f   = 4'b0;
      r   = 32'h0;
      lat = 2;
      if (an || bn) begin
         r    = 32'h7FC00000;
         f[3] = asn || bsn;
      end else if (ai && bi && sa != sb) begin
         r    = 32'h7FC00000;
         f[3] = 1'b1;
      end else if (ai) r = a;
      else if (bi) r = be;
      else if (az && bz) r = {sa && sb, 31'h0};
      else if (az) r = be;
      else if (bz) r = a;
      else begin
         A = 128'({1'b1, a[22:0]});
         B = 128'({1'b1, be[22:0]});
         // A far smaller operand only matters as a tiny nonzero.
         if (ea - eb > 40) begin
            A = A << 40; B = 128'(1); base = ea - 40;
         end else if (eb - ea > 40) begin
            B = B << 40; A = 128'(1); base = eb - 40;
         end else begin
            base = (ea < eb) ? ea : eb;
            A = A << (ea - base);
            B = B << (eb - base);
         end
         if (sa == sb) begin M = A + B; s = sa; end
         else if (A >= B) begin M = A - B; s = sa; end
         else begin M = B - A; s = sb; end
         if (M == 0) begin
            r   = 32'h0;
            lat = 4;
         end else begin
            lat = 6;
            p   = 127;
            while (!M[p]) p--;
            e  = base + p - 23;
            nx = 1'b0;
            if (p > 23) begin
               sh   = p - 23;
               q    = M >> sh;
               rem  = M & ((128'(1) << sh) - 128'(1));
               half = 128'(1) << (sh - 1);
               nx   = (rem != 0);
               if (!rm && (rem > half ||
                   (rem == half && q[0])))
                  q = q + 128'(1);
               if (q[24]) begin q = q >> 1; e = e + 1; end
            end else begin
               q = M << (23 - p);
            end
            if (e >= 255) begin
               f = 4'b0101;
               r = rm ? {s, 31'h7F7FFFFF}
                      : {s, 31'h7F800000};
            end else if (e < 1) begin
               f = 4'b0011;
               r = {s, 31'h0};
            end else begin
               f = {3'b0, nx};
               r = {s, 8'(e), q[22:0]};
            end
         end
      end
   endfunction

   function automatic logic [31:0] gen(
      input logic [31:0] ref_v,
      input bit          near
   );
      logic [31:0] v;
      int          e;
      v = $urandom;
      if (near) begin
         e = int'(ref_v[30:23]) +
             int'($urandom_range(0, 6)) - 3;
         if (e < 1) e = 1;
         if (e > 254) e = 254;
         v[30:23] = 8'(e);
         if ($urandom_range(0, 3) == 0)
            v[22:0] = ref_v[22:0] ^ 23'($urandom_range(0, 7));
         return v;
      end
      case ($urandom_range(0, 19))
         0: v[30:0] = '0;
         1: v[30:23] = '0;
         2: v[30:0] = {8'hFF, 23'h0};
         3: v[30:22] = 9'h1FF;
         4: begin v[30:22] = 9'h1FE; v[0] = 1'b1; end
         5: v[30:23] = 8'(253 + $urandom_range(0, 1));
         6: v[30:23] = 8'($urandom_range(1, 3));
         default: if (v[30:23] == 8'hFF) v[30:23] = 8'h80;
      endcase
      return v;
   endfunction

   task automatic run_op(
      input logic [31:0] a,
      input logic [31:0] b,
      input bit          op,
      input bit          rm,
      input int          hold
   );
      logic [31:0] er;
      logic [3:0]  ef;
      int          el;
      int          lat;
      model(a, b, op, rm, er, ef, el);
      @(negedge clk);
      chk("idle_rdy", 64'(i_ready), 64'(1));
      i_valid = 1'b1;
      i_a     = a;
      i_b     = b;
      i_op    = op;
      i_rm    = rm;
      o_ready = (hold == 0);
      @(negedge clk);
      i_valid = 1'b0;
      i_a     = $urandom;
      i_b     = $urandom;
      i_op    = 1'($urandom);
      i_rm    = 1'($urandom);
      lat     = 1;
      while (!o_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      chk("lat", 64'(lat), 64'(el));
      chk("res", 64'(o_result), 64'(er));
      chk("flg", 64'(o_flags), 64'(ef));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_vld", 64'(o_valid), 64'(1));
         chk("hold_res", 64'(o_result), 64'(er));
         chk("hold_flg", 64'(o_flags), 64'(ef));
         chk("hold_rdy", 64'(i_ready), 64'(0));
      end
      o_ready = 1'b1;
      @(negedge clk);
      chk("ack_vld", 64'(o_valid), 64'(0));
      chk("ack_rdy", 64'(i_ready), 64'(1));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] x, y;
      int          hold;
      rst     = 1'b1;
      i_valid = 1'b0;
      i_op    = 1'b0;
      i_rm    = 1'b0;
      i_a     = '0;
      i_b     = '0;
      o_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rdy", 64'(i_ready), 64'(1));
      chk("rst_vld", 64'(o_valid), 64'(0));
      chk("rst_res", 64'(o_result), 64'(0));
      chk("rst_flg", 64'(o_flags), 64'(0));
      rst = 1'b0;

      run_op(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 0);
      run_op(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 0);
      run_op(32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 0);
      run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 0);
      run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 0);
      run_op(32'h3F800000, 32'h33800000, 1'b0, 1'b0, 0);
      run_op(32'h3F800000, 32'h33800001, 1'b0, 1'b0, 0);
      run_op(32'h3F800001, 32'h3F800000, 1'b1, 1'b0, 0);
      run_op(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 10);

      // Abandon an operation while it is aligning.
      @(negedge clk);
      i_valid = 1'b1;
      i_a     = 32'h3F800000;
      i_b     = 32'h40000000;
      i_op    = 1'b0;
      i_rm    = 1'b0;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rdy", 64'(i_ready), 64'(1));
      chk("mid_vld", 64'(o_valid), 64'(0));
      repeat (8) begin
         @(negedge clk);
         chk("mid_quiet", 64'(o_valid), 64'(0));
      end
      run_op(32'h40400000, 32'hBF800000, 1'b0, 1'b0, 0);

      for (int n = 0; n < 400; n++) begin
         x = gen(32'h0, 1'b0);
         y = ($urandom_range(0, 1) == 1) ? gen(x, 1'b1)
                                        : gen(32'h0, 1'b0);
         hold = ($urandom_range(0, 7) == 0) ?
                int'($urandom_range(1, 3)) : 0;
         run_op(x, y, 1'($urandom), 1'($urandom), hold);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpu_fadd_iter.md
Name: fpu_fadd_iter

Overview:
- Parametrised, handshaked, multi-cycle IEEE-754 binary floating-point add/subtract unit for the FPU execution path.
- Generalises the single-precision adder:
  - configurable exponent/mantissa widths
  - add and subtract opcodes
  - two rounding modes (RNE, RTZ)
  - full special-value handling (zero, inf, NaN)
  - IEEE exception flags
  - strict valid/ready handshake on both sides
- Issue side connects to the FPU dispatch; result side to the write-back arbiter.

Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored fraction width (≥2).
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- i_valid  in  1  operand request valid.
- i_ready  out  1  unit can accept; high only in IDLE.
- i_op  in  1  0 = a+b, 1 = a-b.
- i_rm  in  1  0 = round-to-nearest-even, 1 = round-toward-zero.
- i_a  in  W  operand a.
- i_b  in  W  operand b.
- o_valid  out  1  result valid; held until accepted.
- o_ready  in  1  consumer accepts result.
- o_result  out  W  result.
- o_flags  out  4  {NV, OF, UF, NX}; held with o_result.

Behaviour:
- Reset (rst=1 at a clock edge) → state IDLE; i_ready=1, o_valid=0, o_result=0, o_flags=0. Reset mid-operation abandons the operation silently, with no output.
- Accept: i_valid & i_ready at edge T → a, b, op, rm registered. b's sign is inverted when op=1. State → CLASS.
- CLASS (cycle T+1): decode exponent/fraction. Subnormal inputs are flushed to signed zero (DAZ). Special operations go to DONE, so o_valid is high in cycle T+2:
  - any NaN → canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0); NV=1 if any operand is an sNaN.
  - +inf + -inf (effective) → canonical qNaN, NV=1.
  - one inf → that inf.
  - both zero → +0 if signs differ (RNE and RTZ), else that signed zero.
  - one zero → other operand unchanged.
- Otherwise → ALIGN.
- ALIGN (T+2):
  - Swap so the larger magnitude is operand L.
  - Right-shift the small mantissa (hidden 1 included) by the exponent difference in one cycle. Extended width is MAN_W+4: hidden, fraction, guard, round, sticky.
  - Shifted-out bits OR into sticky. A difference > MAN_W+3 leaves sticky only.
- ADD (T+3): same effective sign → add, with 1 carry bit. Otherwise subtract small from L. Exact zero result → +0 (RNE and RTZ), go to DONE.
- NORM (T+4):
  - Carry out → right-shift 1 (sticky preserved), exponent+1.
  - Else left-shift by the leading-zero count (single cycle, via sub-module); exponent decreases by that count.
  - Exponent arithmetic is signed, width EXP_W+2.
- ROUND (T+5):
  - RNE: increment when G & (R|S|LSB).
  - RTZ: truncate.
  - NX = G|R|S.
  - Mantissa overflow from rounding → exponent+1.
  - Biased exponent ≥ all-ones → OF=1, NX=1; RNE gives ±inf, RTZ gives ±max finite.
  - Biased exponent < 1 → FTZ to signed zero; UF=1, NX=1.
- DONE (T+6 normal path): o_valid=1; o_result and o_flags stable. If o_ready is low, hold indefinitely. o_valid & o_ready at an edge → IDLE, o_valid=0, i_ready=1 the next cycle (no same-cycle re-accept).
- Fixed latency: 2 cycles for the special path, 6 cycles for the normal path (edge of acceptance to first o_valid cycle).
- While busy, i_a/i_b/i_op/i_rm are ignored.

Decomposition:
- Package fpu_fadd_pkg:
  - state encodings (IDLE, CLASS, ALIGN, ADD, NORM, ROUND, DONE)
  - flag bit indices (NV=3, OF=2, UF=1, NX=0)
  - rounding-mode constants
  - canonical-NaN constructor function parametrised by EXP_W/MAN_W
- One sub-module, fpu_lzc: parametrised combinational leading-zero counter over MAN_W+2 bits. Output is the count; an all-zero flag is included.

Test Plan (EXP_W=8, MAN_W=23):
- a=0x3F800000, b=0x40000000, op=0, RNE → 0x40400000, flags 0; o_valid first seen 6 cycles after accept.
- a=0x3F800000, b=0x3F800000, op=1 → 0x00000000, flags 0; a=0x7F800000, b=0x7F800000, op=1 → 0x7FC00000, NV=1, o_valid after 2 cycles.
- a=b=0x7F7FFFFF, op=0: RNE → 0x7F800000, OF|NX; RTZ → 0x7F7FFFFF, OF|NX.
- Ties: a=0x3F800000, b=0x33800000, RNE → 0x3F800000, NX; b=0x33800001 → 0x3F800001, NX.
- Cancellation: a=0x3F800001, b=0x3F800000, op=1 → 0x34000000, flags 0 (tests LZC shift of 23).
- Backpressure/reset: hold o_ready=0 for 10 cycles → o_valid/o_result stable and i_ready=0 throughout. Assert rst during ALIGN → next cycle i_ready=1, o_valid=0; a new operation then completes correctly.
